// File: rtl/auth_cmd_rx.sv
// 8N1 UART receiver feeding the rider-power authorization state machine.
// A stop request is held pending until the load cells report no rider.
module auth_cmd_rx #(
    parameter int         BAUD_DIV = 2604,
    parameter logic [7:0] CMD_GO   = 8'h47,
    parameter logic [7:0] CMD_STOP = 8'h53
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       rider_off,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err,
    output logic       pwr_up
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {AUTH_OFF, AUTH_PWR1, AUTH_PWR2} auth_state_t;

    logic rx_meta, rx_s, rx_prev;

    rx_state_t   rx_state, rx_state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [3:0]  bit_cnt, bit_cnt_d;
    logic [7:0]  shift, shift_d;
    logic [7:0]  rx_data_d;
    logic        rx_rdy_d, frm_err_d;
    logic        expire;

    auth_state_t auth_state, auth_state_d;

    // rx_prev holds the previous synchronized sample for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_rdy   <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            rx_state <= rx_state_d;
            cnt      <= cnt_d;
            bit_cnt  <= bit_cnt_d;
            shift    <= shift_d;
            rx_data  <= rx_data_d;
            rx_rdy   <= rx_rdy_d;
            frm_err  <= frm_err_d;
        end
    end

    // A loaded count of N produces its expiry action N cycles later.
    assign expire = (cnt == CW'(1));

    always_comb begin
        rx_state_d = rx_state;
        cnt_d      = (cnt != '0) ? cnt - CW'(1) : cnt;
        bit_cnt_d  = bit_cnt;
        shift_d    = shift;
        rx_data_d  = rx_data;
        rx_rdy_d   = 1'b0;
        frm_err_d  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    cnt_d      = HALF_BIT;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (expire) begin
                    if (rx_s) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        cnt_d      = FULL_BIT;
                        bit_cnt_d  = '0;
                        rx_state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (expire) begin
                    shift_d   = {rx_s, shift[7:1]};
                    cnt_d     = FULL_BIT;
                    bit_cnt_d = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (expire) begin
                    if (rx_s) begin
                        rx_data_d = shift;
                        rx_rdy_d  = 1'b1;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auth_state <= AUTH_OFF;
            pwr_up     <= 1'b0;
        end else begin
            auth_state <= auth_state_d;
            pwr_up     <= (auth_state_d != AUTH_OFF);
        end
    end

    // In PWR2 a fresh GO outranks a simultaneous rider_off.
    always_comb begin
        auth_state_d = auth_state;
        case (auth_state)
            AUTH_OFF: begin
                if (rx_rdy && rx_data == CMD_GO) begin
                    auth_state_d = AUTH_PWR1;
                end
            end
            AUTH_PWR1: begin
                if (rx_rdy && rx_data == CMD_STOP) begin
                    auth_state_d = rider_off ? AUTH_OFF : AUTH_PWR2;
                end
            end
            AUTH_PWR2: begin
                if (rx_rdy && rx_data == CMD_GO) begin
                    auth_state_d = AUTH_PWR1;
                end else if (rider_off) begin
                    auth_state_d = AUTH_OFF;
                end
            end
            default: auth_state_d = AUTH_OFF;
        endcase
    end

endmodule

// File: tb/tb_auth_cmd_rx.sv
// Directed bench for auth_cmd_rx: UART framing, glitch/reset handling and
// the authorization sequence, with BAUD_DIV shortened to 16.
module tb_auth_cmd_rx;

    localparam int BD = 16;
    localparam int LAT = 3 + BD / 2 + 9 * BD;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX;
    logic       rider_off;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       frm_err;
    logic       pwr_up;

    int n_checks = 0;
    int n_fail   = 0;

    int         cyc = 0;
    int         rdy_cnt = 0;
    int         err_cnt = 0;
    int         both_cnt = 0;
    int         t_rdy = 0;
    int         t_start = 0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] data_at_err = 8'h00;
    logic       pwr_at_rdy = 1'b0;
    logic       pwr_after = 1'b0;
    logic       rdy_prev = 1'b0;

    auth_cmd_rx #(
        .BAUD_DIV(BD),
        .CMD_GO  (8'h47),
        .CMD_STOP(8'h53)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .RX       (RX),
        .rider_off(rider_off),
        .rx_data  (rx_data),
        .rx_rdy   (rx_rdy),
        .frm_err  (frm_err),
        .pwr_up   (pwr_up)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse observer, sampled on the falling edge.
    always @(negedge clk) begin
        if (rdy_prev) pwr_after <= pwr_up;
        rdy_prev <= rx_rdy;
        if (rx_rdy) begin
            rdy_cnt    <= rdy_cnt + 1;
            last_data  <= rx_data;
            t_rdy      <= cyc;
            pwr_at_rdy <= pwr_up;
        end
        if (frm_err) begin
            err_cnt     <= err_cnt + 1;
            data_at_err <= rx_data;
        end
        if (rx_rdy && frm_err) both_cnt <= both_cnt + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; leaves the line high, so calls chain back-to-back.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        RX = 1'b0;
        t_start = cyc;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = stop_bit;
        repeat (BD) @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        RX = 1'b1;
        rider_off = 1'b0;
        idle(3);
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        n_checks++; if (rx_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_rdy got %b want 0", rx_rdy); end
        n_checks++; if (frm_err !== 1'b0) begin n_fail++; $display("FAIL reset_frm_err got %b want 0", frm_err); end
        n_checks++; if (pwr_up !== 1'b0) begin n_fail++; $display("FAIL reset_pwr_up got %b want 0", pwr_up); end
        rst = 1'b0;
        idle(1000);
        n_checks++; if (rdy_cnt !== 0) begin n_fail++; $display("FAIL idle_no_rdy got %0d want 0", rdy_cnt); end
        n_checks++; if (err_cnt !== 0) begin n_fail++; $display("FAIL idle_no_err got %0d want 0", err_cnt); end
        n_checks++; if (pwr_up !== 1'b0) begin n_fail++; $display("FAIL idle_pwr_up got %b want 0", pwr_up); end
    endtask

    task automatic test_go;
        int r0;
        int lat;
        r0 = rdy_cnt;
        send_frame(8'h47, 1'b1);
        idle(4);
        lat = t_rdy - t_start;
        n_checks++; if (rdy_cnt !== r0 + 1) begin n_fail++; $display("FAIL go_rdy_count got %0d want %0d", rdy_cnt - r0, 1); end
        n_checks++; if (last_data !== 8'h47) begin n_fail++; $display("FAIL go_data got %h want 47", last_data); end
        n_checks++; if (rx_data !== 8'h47) begin n_fail++; $display("FAIL go_data_held got %h want 47", rx_data); end
        n_checks++; if (lat < LAT - 2 || lat > LAT + 2) begin n_fail++; $display("FAIL go_latency got %0d want %0d+-2", lat, LAT); end
        n_checks++; if (pwr_at_rdy !== 1'b0) begin n_fail++; $display("FAIL go_pwr_at_rdy got %b want 0", pwr_at_rdy); end
        n_checks++; if (pwr_after !== 1'b1) begin n_fail++; $display("FAIL go_pwr_next got %b want 1", pwr_after); end
    endtask

    task automatic test_stop_pending;
        int r0;
        r0 = rdy_cnt;
        send_frame(8'h53, 1'b1);
        idle(4);
        n_checks++; if (rdy_cnt !== r0 + 1) begin n_fail++; $display("FAIL stop_rdy_count got %0d want 1", rdy_cnt - r0); end
        n_checks++; if (pwr_after !== 1'b1) begin n_fail++; $display("FAIL stop_rider_on_pwr got %b want 1", pwr_after); end
        idle(500);
        n_checks++; if (pwr_up !== 1'b1) begin n_fail++; $display("FAIL stop_pending_hold got %b want 1", pwr_up); end
        rider_off = 1'b1;
        @(negedge clk);
        n_checks++; if (pwr_up !== 1'b0) begin n_fail++; $display("FAIL rider_off_drop got %b want 0", pwr_up); end
        rider_off = 1'b0;
        idle(2);
        r0 = rdy_cnt;
        send_frame(8'h53, 1'b1);
        idle(4);
        n_checks++; if (rdy_cnt !== r0 + 1) begin n_fail++; $display("FAIL off_stop_rdy got %0d want 1", rdy_cnt - r0); end
        n_checks++; if (pwr_up !== 1'b0) begin n_fail++; $display("FAIL off_stop_pwr got %b want 0", pwr_up); end
    endtask

    task automatic test_go_priority;
        logic seen;
        seen = 1'b0;
        send_frame(8'h47, 1'b1);
        idle(4);
        n_checks++; if (pwr_up !== 1'b1) begin n_fail++; $display("FAIL prio_go_pwr got %b want 1", pwr_up); end
        send_frame(8'h53, 1'b1);
        idle(4);
        n_checks++; if (pwr_up !== 1'b1) begin n_fail++; $display("FAIL prio_pwr2_pwr got %b want 1", pwr_up); end
        fork
            send_frame(8'h47, 1'b1);
            begin
                for (int i = 0; i < 400 && !seen; i++) begin
                    @(negedge clk);
                    if (rx_rdy) seen = 1'b1;
                end
                if (seen) begin
                    rider_off = 1'b1;
                    @(negedge clk);
                    rider_off = 1'b0;
                end
            end
        join
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL prio_rdy_timeout got %b want 1", seen); end
        idle(20);
        n_checks++; if (pwr_up !== 1'b1) begin n_fail++; $display("FAIL prio_go_wins got %b want 1", pwr_up); end
        rider_off = 1'b1;
        idle(5);
        n_checks++; if (pwr_up !== 1'b1) begin n_fail++; $display("FAIL prio_is_pwr1 got %b want 1", pwr_up); end
        send_frame(8'h53, 1'b1);
        idle(4);
        n_checks++; if (pwr_at_rdy !== 1'b1) begin n_fail++; $display("FAIL prio_stop_before got %b want 1", pwr_at_rdy); end
        n_checks++; if (pwr_after !== 1'b0) begin n_fail++; $display("FAIL prio_stop_off got %b want 0", pwr_after); end
        rider_off = 1'b0;
    endtask

    task automatic test_frame_error;
        int r0;
        int e0;
        r0 = rdy_cnt;
        e0 = err_cnt;
        send_frame(8'hA5, 1'b0);
        idle(BD);
        n_checks++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL ferr_count got %0d want 1", err_cnt - e0); end
        n_checks++; if (rdy_cnt !== r0) begin n_fail++; $display("FAIL ferr_no_rdy got %0d want 0", rdy_cnt - r0); end
        n_checks++; if (rx_data !== 8'h53) begin n_fail++; $display("FAIL ferr_data_kept got %h want 53", rx_data); end
        n_checks++; if (data_at_err !== 8'h53) begin n_fail++; $display("FAIL ferr_data_at_pulse got %h want 53", data_at_err); end
        send_frame(8'h3C, 1'b1);
        n_checks++; if (last_data !== 8'h3C) begin n_fail++; $display("FAIL b2b_first got %h want 3c", last_data); end
        send_frame(8'h47, 1'b1);
        idle(4);
        n_checks++; if (rdy_cnt !== r0 + 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", rdy_cnt - r0); end
        n_checks++; if (last_data !== 8'h47) begin n_fail++; $display("FAIL b2b_second got %h want 47", last_data); end
        n_checks++; if (pwr_up !== 1'b1) begin n_fail++; $display("FAIL b2b_pwr got %b want 1", pwr_up); end
        n_checks++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL b2b_no_err got %0d want 1", err_cnt - e0); end
    endtask

    task automatic test_glitch;
        int r0;
        int e0;
        r0 = rdy_cnt;
        e0 = err_cnt;
        RX = 1'b0;
        idle(3);
        RX = 1'b1;
        idle(2 * BD);
        n_checks++; if (rdy_cnt !== r0) begin n_fail++; $display("FAIL glitch_no_rdy got %0d want 0", rdy_cnt - r0); end
        n_checks++; if (err_cnt !== e0) begin n_fail++; $display("FAIL glitch_no_err got %0d want 0", err_cnt - e0); end
        send_frame(8'h3C, 1'b1);
        idle(4);
        n_checks++; if (rdy_cnt !== r0 + 1) begin n_fail++; $display("FAIL glitch_then_rdy got %0d want 1", rdy_cnt - r0); end
        n_checks++; if (last_data !== 8'h3C) begin n_fail++; $display("FAIL glitch_then_data got %h want 3c", last_data); end
        n_checks++; if (pwr_up !== 1'b1) begin n_fail++; $display("FAIL other_byte_pwr got %b want 1", pwr_up); end
    endtask

    task automatic test_reset_mid;
        int r0;
        r0 = rdy_cnt;
        fork
            send_frame(8'h47, 1'b1);
            begin
                idle(40);
                rst = 1'b1;
                @(negedge clk);
                n_checks++; if (pwr_up !== 1'b0) begin n_fail++; $display("FAIL midrst_pwr_in_rst got %b want 0", pwr_up); end
                idle(130);
                rst = 1'b0;
            end
        join
        idle(2 * BD);
        n_checks++; if (rdy_cnt !== r0) begin n_fail++; $display("FAIL midrst_no_rdy got %0d want 0", rdy_cnt - r0); end
        n_checks++; if (pwr_up !== 1'b0) begin n_fail++; $display("FAIL midrst_pwr got %b want 0", pwr_up); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data got %h want 00", rx_data); end
        send_frame(8'h47, 1'b1);
        idle(4);
        n_checks++; if (rdy_cnt !== r0 + 1) begin n_fail++; $display("FAIL postrst_rdy got %0d want 1", rdy_cnt - r0); end
        n_checks++; if (last_data !== 8'h47) begin n_fail++; $display("FAIL postrst_data got %h want 47", last_data); end
        n_checks++; if (pwr_up !== 1'b1) begin n_fail++; $display("FAIL postrst_pwr got %b want 1", pwr_up); end
    endtask

    initial begin
        rst = 1'b1;
        RX = 1'b1;
        rider_off = 1'b0;
        test_reset;
        test_go;
        test_stop_pending;
        test_go_priority;
        test_frame_error;
        test_glitch;
        test_reset_mid;
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL rdy_err_overlap got %0d want 0", both_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/auth_cmd_rx.md
# auth_cmd_rx

Receive side of the BLE command link into the Segway. The block deserializes 8N1 UART bytes on `RX` (driven by the host's `UART_tx`) and runs the authorization state machine that gates rider power. `pwr_up` enables the balance controller and motor drive. A stop command is honoured only once the rider has stepped off.

## Interface
Parameters:
- `BAUD_DIV`, default 2604: clocks per bit (50 MHz / 19200 baud). Must be ≥ 8 and even.
- `CMD_GO`, default 8'h47 ('G'): authorize/start code.
- `CMD_STOP`, default 8'h53 ('S'): stop code.

Ports:
- `clk`, input, 1: system clock, all logic on rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `RX`, input, 1: serial line, idle high, asynchronous to `clk`.
- `rider_off`, input, 1: high when load cells show no rider (synchronous to `clk`).
- `rx_data`, output, 8: last correctly framed byte. Held until the next good byte.
- `rx_rdy`, output, 1: one-cycle pulse when `rx_data` is updated.
- `frm_err`, output, 1: one-cycle pulse when the stop bit is sampled low. The byte is discarded.
- `pwr_up`, output, 1: rider power authorized.

## Operation
Input conditioning:
- `RX` passes through a two-flop synchronizer. Both flops reset to 1. Only the synchronized value (`rx_s`) is used downstream.

Receiver FSM, with states IDLE, START, DATA, STOP:
- IDLE: when `rx_s` falls from 1 to 0, load the baud counter with `BAUD_DIV/2` and go to START.
- START: when the counter expires, sample `rx_s`.
  - If it is 1, treat it as a glitch and return to IDLE. No pulse.
  - If it is 0, reload the counter with `BAUD_DIV`, clear the bit count, and go to DATA.
- DATA: on each expiry, shift `rx_s` into the shift register (LSB first) and reload the counter. After the 8th bit, go to STOP.
- STOP: on expiry, sample `rx_s`.
  - If it is 1, copy the shift register to `rx_data` and pulse `rx_rdy`.
  - If it is 0, pulse `frm_err`.
  - In both cases return to IDLE in the same cycle. The next falling edge is accepted immediately.
- Counter width is `$clog2(BAUD_DIV+1)`. Bit count is 4 bits.

Auth FSM, with states OFF, PWR1, PWR2, evaluated on `rx_rdy`:
- OFF:
  - `CMD_GO` → PWR1.
  - Any other byte → stay in OFF.
- PWR1 (powered, rider allowed):
  - `CMD_STOP` with `rider_off`=1 → OFF.
  - `CMD_STOP` with `rider_off`=0 → PWR2.
  - Other bytes → stay in PWR1.
- PWR2 (stop pending, still powered):
  - `rider_off`=1 at any cycle → OFF.
  - `rx_rdy` with `CMD_GO` → PWR1. This takes priority over `rider_off` in the same cycle.
  - Other bytes → stay in PWR2.
- `pwr_up` = (state != OFF), registered.
- `frm_err` never changes auth state.

## Timing
- Reset values:
  - Receiver FSM = IDLE, auth FSM = OFF.
  - `rx_data` = 0.
  - `rx_rdy` = 0, `frm_err` = 0, `pwr_up` = 0.
  - Both synchronizer flops = 1.
- Reset mid-frame: the partial byte is abandoned and no pulse is produced. The receiver resyncs on the next falling edge after `rst` drops.
  - If reset releases while `RX` is low mid-frame, a spurious start is possible. It is rejected only if `rx_s` is high at the half-bit sample.
- Latency from the `RX` falling edge to `rx_rdy`: 2 (sync) + 1 (edge detect) + `BAUD_DIV/2` + 9·`BAUD_DIV` cycles. Benches allow ±2 cycles.
- `rx_data` is valid on the same cycle `rx_rdy` is high.
- `pwr_up` changes on the cycle after `rx_rdy` (or after `rider_off` rises, in PWR2).
- `rx_rdy` and `frm_err` are mutually exclusive.
- No handshake back to the sender. Back-to-back frames with 1 stop bit are received without loss.

## Test plan
- Reset, line idle, `BAUD_DIV`=16 → all outputs 0. No `rx_rdy` for 1000 cycles.
- Send 0x47 → exactly one `rx_rdy` with `rx_data`=0x47. `pwr_up` rises the next cycle.
- From PWR1, send 0x53 with `rider_off`=0 → `pwr_up` stays 1. Raise `rider_off` 500 cycles later → `pwr_up`=0 one cycle later. Then from OFF, send 0x53 → `pwr_up` stays 0.
- From PWR2, send 0x47 and pulse `rider_off` on the same cycle as `rx_rdy` → state PWR1, `pwr_up` stays 1. A later 0x53 with `rider_off`=1 → `pwr_up`=0.
- Frame 0xA5 with the stop bit forced low → one `frm_err` pulse, no `rx_rdy`, `rx_data` unchanged. Then send 0x3C back-to-back → `rx_rdy`, `rx_data`=0x3C.
- Glitches and reset:
  - A 3-cycle low glitch on `RX` → no pulse, FSM back in IDLE.
  - Assert `rst` mid-frame of 0x47 → `pwr_up`=0, no `rx_rdy`.
  - After reset, a full 0x47 → `pwr_up`=1.
